// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared immediate-format types, opcodes and range helper
package imm_pkg;

    typedef enum logic [1:0] {
        IMM_I   = 2'b00,
        IMM_S   = 2'b01,
        IMM_B   = 2'b10,
        IMM_BAD = 2'b11
    } imm_src_e;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    // True when every bit from position top upward equals the sign bit,
    // i.e. the value survives truncation to a (top+1)-bit signed field.
    function automatic logic imm_fits(input logic [31:0] imm, input int unsigned top);
        logic [31:0] s;
        s = $signed(imm) >>> top;
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - combinational I/S/B instruction packer with immediate range check
module imm_pack
    import imm_pkg::*;
(
    input  imm_src_e    i_imm_src,
    input  logic [31:0] i_imm,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    output logic [31:0] o_word,
    output logic        o_ok
);

    // Select the field layout and the matching legality rule for the immediate
    always_comb begin
        o_word = '0;
        o_ok   = 1'b0;
        case (i_imm_src)
            IMM_I: begin
                o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_ok   = imm_fits(i_imm, 11);
            end
            IMM_S: begin
                o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_ok   = imm_fits(i_imm, 11);
            end
            IMM_B: begin
                o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                          i_imm[4:1], i_imm[11], i_opcode};
                o_ok   = imm_fits(i_imm, 12) && !i_imm[0];
            end
            default: begin
                o_word = '0;
                o_ok   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - registered instruction encoder streaming words to instr memory
module imm_encoder
    import imm_pkg::*;
#(
    parameter int                    INSTRUCTION_WIDTH = 32,
    parameter int                    ADDR_WIDTH        = 32,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR        = '0,
    parameter int                    ERR_CNT_WIDTH     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   ImmSrc,
    input  logic [31:0]                  Imm,
    input  logic [6:0]                   opcode,
    input  logic [4:0]                   rd,
    input  logic [2:0]                   funct3,
    input  logic [4:0]                   rs1,
    input  logic [4:0]                   rs2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
    output logic                         err_sticky,
    output logic [ERR_CNT_WIDTH-1:0]     err_count
);

    logic                         r_out_valid;
    logic [INSTRUCTION_WIDTH-1:0] r_wdata;
    logic [ADDR_WIDTH-1:0]        r_addr;
    logic                         r_err_sticky;
    logic [ERR_CNT_WIDTH-1:0]     r_err_count;

    logic [31:0] w_word;
    logic        w_ok;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_xfer;

    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_xfer     = r_out_valid && out_ready;

    imm_pack u_pack (
        .i_imm_src (imm_src_e'(ImmSrc)),
        .i_imm     (Imm),
        .i_opcode  (opcode),
        .i_rd      (rd),
        .i_funct3  (funct3),
        .i_rs1     (rs1),
        .i_rs2     (rs2),
        .o_word    (w_word),
        .o_ok      (w_ok)
    );

    // Output holding register: load on a legal accept, empty on transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_wdata     <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_wdata     <= '0;
        end else if (w_accept && w_ok) begin
            r_out_valid <= 1'b1;
            r_wdata     <= w_word;
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    // Byte address of the held word: step one word per completed transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= START_ADDR;
        end else if (flush) begin
            r_addr <= START_ADDR;
        end else if (w_xfer) begin
            r_addr <= r_addr + ADDR_WIDTH'(4);
        end
    end

    // Rejected inputs are consumed but flagged and counted (saturating)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else if (flush) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else if (w_accept && !w_ok) begin
            r_err_sticky <= 1'b1;
            if (r_err_count != '1) begin
                r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign mem_wdata  = r_wdata;
    assign mem_addr   = r_addr;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - scoreboard bench for imm_encoder
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ImmSrc;
    logic [31:0] Imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        err_sticky;
    logic [7:0]  err_count;

    imm_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ImmSrc     (ImmSrc),
        .Imm        (Imm),
        .opcode     (opcode),
        .rd         (rd),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] imm;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        bit          has;
        logic [31:0] word;
    } item_t;

    item_t       q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_addr   = 0;
    int          m_err    = 0;
    bit          m_sticky = 0;
    bit          hold     = 0;
    logic [31:0] h_addr, h_data;
    bit          tb_has;
    logic [31:0] tb_word;
    bit          rdone;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit golden_ok(input logic [1:0] s, input logic [31:0] imm);
        int v;
        v = imm;
        case (s)
            2'b00, 2'b01: return (v >= -2048) && (v <= 2047);
            2'b10:        return (v >= -4096) && (v <= 4095) && (imm[0] == 1'b0);
            default:      return 1'b0;
        endcase
    endfunction

    // Core-style immediate extender plus field extraction from an emitted word
    function automatic logic [63:0] decode(input logic [31:0] w, input logic [1:0] s);
        logic [31:0] ext;
        logic [4:0]  r;
        case (s)
            2'b00:   ext = {{20{w[31]}}, w[31:20]};
            2'b01:   ext = {{20{w[31]}}, w[31:25], w[11:7]};
            default: ext = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        endcase
        r = (s == 2'b00) ? w[11:7] : w[24:20];
        return 64'({ext, w[6:0], w[14:12], w[19:15], r});
    endfunction

    function automatic logic [63:0] expect_key(input item_t it);
        return 64'({it.imm, it.opc, it.f3, it.rs1, (it.src == 2'b00) ? it.rd : it.rs2});
    endfunction

    // Mid-cycle monitor: check DUT state against the model, then advance the model
    always @(negedge clk) begin
        item_t it;
        bit    acc;
        if (!rst_n) begin
            q.delete();
            m_addr = 0; m_err = 0; m_sticky = 0; hold = 0;
        end else begin
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'((q.size() == 0) || out_ready));
            chk("err_count", 64'(err_count), 64'(m_err));
            chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
            if (hold && out_valid)
                chk("hold_stable", {mem_addr, mem_wdata}, {h_addr, h_data});
            if (flush) begin
                q.delete();
                m_addr = 0; m_err = 0; m_sticky = 0; hold = 0;
            end else begin
                acc    = in_valid && ((q.size() == 0) || out_ready);
                hold   = out_valid && !out_ready;
                h_addr = mem_addr;
                h_data = mem_wdata;
                if (out_valid && out_ready && q.size() > 0) begin
                    it = q.pop_front();
                    chk("addr", 64'(mem_addr), 64'(m_addr));
                    chk("roundtrip", decode(mem_wdata, it.src), expect_key(it));
                    if (it.has) chk("word", 64'(mem_wdata), 64'(it.word));
                    m_addr = m_addr + 4;
                end
                if (acc) begin
                    if (golden_ok(ImmSrc, Imm)) begin
                        it = '{ImmSrc, Imm, opcode, rd, funct3, rs1, rs2, tb_has, tb_word};
                        q.push_back(it);
                    end else begin
                        m_sticky = 1;
                        if (m_err != 255) m_err++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [1:0] s, input logic [31:0] imm, input logic [6:0] opc,
                        input logic [4:0] rd_i, input logic [2:0] f3, input logic [4:0] rs1_i,
                        input logic [4:0] rs2_i, input bit has, input logic [31:0] word);
        bit acc = 0;
        ImmSrc = s; Imm = imm; opcode = opc; rd = rd_i; funct3 = f3;
        rs1 = rs1_i; rs2 = rs2_i; tb_has = has; tb_word = word;
        in_valid = 1'b1;
        for (int n = 0; n < 64 && !acc; n++) begin
            @(negedge clk);
            #1 acc = in_ready;
            tick();
        end
        if (!acc) chk("send_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic send_rand();
        logic [31:0] r;
        logic [31:0] imm;
        r   = $urandom;
        imm = ($urandom_range(0, 9) == 0) ? $urandom : {{18{r[13]}}, r[13:0]};
        send(2'($urandom_range(0, 3)), imm, 7'($urandom), 5'($urandom), 3'($urandom),
             5'($urandom), 5'($urandom), 1'b0, 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ImmSrc = 0; Imm = 0; opcode = 0; rd = 0; funct3 = 0; rs1 = 0; rs2 = 0;
        tb_has = 0; tb_word = 0; rdone = 0;
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_err", {err_sticky, err_count}, 64'(0));
        tick();
        rst_n = 1'b1;
        #1 chk("rst_in_ready", 64'(in_ready), 64'(1));
        tick();

        // Directed encodings and latency
        out_ready = 1'b1;
        send(2'b00, 32'hFFFF_FFFF, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 1'b1, 32'hFFF10093);
        chk("lat_valid", 64'(out_valid), 64'(1));
        chk("lat_word", 64'(mem_wdata), 64'(32'hFFF10093));
        chk("lat_addr", 64'(mem_addr), 64'(0));
        send(2'b01, 32'd8, 7'h23, 5'd0, 3'd2, 5'd2, 5'd5, 1'b1, 32'h00512423);
        send(2'b10, 32'hFFFF_FFFC, 7'h63, 5'd0, 3'd1, 5'd1, 5'd0, 1'b1, 32'hFE009EE3);
        send(2'b10, 32'd3, 7'h63, 5'd0, 3'd1, 5'd1, 5'd0, 1'b0, 32'h0);
        tick();
        chk("b_odd_err_count", 64'(err_count), 64'(1));
        chk("b_odd_sticky", 64'(err_sticky), 64'(1));

        // Range boundary for I-type
        do_flush();
        chk("flush_err", {err_sticky, err_count}, 64'(0));
        send(2'b00, 32'd2048, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        chk("i2048_no_valid", 64'(out_valid), 64'(0));
        chk("i2048_sticky", 64'(err_sticky), 64'(1));
        send(2'b00, 32'hFFFF_F800, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 1'b1, 32'h80000013);
        send(2'b01, 32'd2047, 7'h23, 5'd0, 3'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        send(2'b10, 32'hFFFF_F000, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        send(2'b10, 32'd4096, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        tick();

        // Backpressure: out_ready low for 3 cycles while streaming 4 words
        do_flush();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(2'b00, 32'(i * 16), 7'h13, 5'(i), 3'd0, 5'd3, 5'd0, 1'b0, 32'h0);
            end
            begin
                tick();
                chk("bp_valid", 64'(out_valid), 64'(1));
                chk("bp_in_ready", 64'(in_ready), 64'(0));
                tick();
                tick();
                out_ready = 1'b1;
            end
        join
        tick(); tick(); tick();
        chk("bp_final_addr", 64'(mem_addr), 64'(16));
        chk("bp_drained", 64'(q.size()), 64'(0));

        // Flush while a word is held
        out_ready = 1'b0;
        send(2'b00, 32'd5, 7'h13, 5'd1, 3'd0, 5'd1, 5'd0, 1'b0, 32'h0);
        chk("pre_flush_valid", 64'(out_valid), 64'(1));
        do_flush();
        chk("flush_valid", 64'(out_valid), 64'(0));
        chk("flush_addr", 64'(mem_addr), 64'(0));
        chk("flush_wdata", 64'(mem_wdata), 64'(0));

        // Asynchronous reset while a word is held
        send(2'b00, 32'd6, 7'h13, 5'd1, 3'd0, 5'd1, 5'd0, 1'b0, 32'h0);
        tick();
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        #3 rst_n = 1'b0;
        #1 chk("arst_valid", 64'(out_valid), 64'(0));
        chk("arst_addr", 64'(mem_addr), 64'(0));
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        // Error counter saturation
        for (int i = 0; i < 260; i++)
            send(2'b11, 32'd0, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        tick();
        chk("err_saturate", 64'(err_count), 64'(255));
        do_flush();

        // Random round trip with random output backpressure
        fork
            begin
                for (int i = 0; i < 10000; i++) send_rand();
                rdone = 1;
            end
            begin
                while (!rdone) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        out_ready = 1'b1;
        for (int n = 0; n < 20 && q.size() != 0; n++) tick();
        chk("rand_drain", 64'(q.size()), 64'(0));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
